// File: rtl/prime_pkg.sv
// Shared types and defaults for the prime result collector: widths, FSM state enum, FIFO entry.
package prime_pkg;

    localparam int NUM_W      = 10;
    localparam int CNT_W      = 8;
    localparam int FIFO_DEPTH = 8;

    // Gap between the two members of a twin-prime pair.
    localparam logic [NUM_W-1:0] TWIN_GAP = NUM_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } coll_state_e;

    typedef struct packed {
        logic [NUM_W-1:0] num;
        logic [NUM_W-1:0] gap;
    } prime_entry_t;

endpackage

// File: rtl/prime_fifo.sv
// Synchronous FIFO of prime_entry_t; full/empty are decoded from read/write pointers
// that carry one extra wrap bit above the address.
module prime_fifo
    import prime_pkg::*;
#(
    parameter int DEPTH = prime_pkg::FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  prime_entry_t data_i,
    input  logic         pop_i,
    output prime_entry_t data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    prime_entry_t mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Same address with differing wrap bits means the writer is a full lap ahead.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/prime_result_collector.sv
// Collects the prime checker's result stream, buffers primes with their gaps and keeps statistics.
// Optional macro TWIN_PRIME_EN adds the TwinCount output (twin-prime pairs seen).
module prime_result_collector
    import prime_pkg::*;
#(
    parameter int CNT_W      = prime_pkg::CNT_W,
    parameter int FIFO_DEPTH = prime_pkg::FIFO_DEPTH
) (
    input  logic             SysClk,
    input  logic             Reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [NUM_W-1:0] InNumber,
    input  logic             InPrime,
    input  logic             InLast,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [NUM_W-1:0] OutPrime,
    output logic [NUM_W-1:0] OutGap,
    output logic [CNT_W-1:0] PrimeCount,
    output logic [NUM_W-1:0] MaxGap,
    output logic             Overflow,
`ifdef TWIN_PRIME_EN
    output logic [CNT_W-1:0] TwinCount,
`endif
    output logic             Done
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    coll_state_e      state_q;
    logic             done_q;
    logic [NUM_W-1:0] last_prime_q;
    logic             have_first_q;
    logic [NUM_W-1:0] max_gap_q;
    logic [CNT_W-1:0] prime_count_q;
    logic [CNT_W-1:0] prime_count_d;
    logic             overflow_q;
    logic [NUM_W-1:0] gap_d;

    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    prime_entry_t     push_entry;
    prime_entry_t     head;

    // NOTE: handshake terms are continuous assigns, so every path is driven and no latch can form.
    assign InReady = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !fifo_full;
    assign accept  = InValid && InReady;
    assign push    = accept && InPrime;
    assign pop     = OutValid && OutReady;

    // Modular subtraction keeps the gap well defined even for out-of-order input.
    assign gap_d         = have_first_q ? (InNumber - last_prime_q) : '0;
    assign prime_count_d = (prime_count_q == CNT_MAX) ? prime_count_q : prime_count_q + CNT_ONE;

    assign push_entry.num = InNumber;
    assign push_entry.gap = gap_d;

    prime_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (SysClk),
        .rst_n   (Reset_n),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign OutValid   = !fifo_empty;
    assign OutPrime   = head.num;
    assign OutGap     = head.gap;
    assign PrimeCount = prime_count_q;
    assign MaxGap     = max_gap_q;
    assign Overflow   = overflow_q;
    assign Done       = done_q;

    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= InLast ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && InLast) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TWIN_PRIME_EN
    logic [CNT_W-1:0] twin_count_q;
    logic             twin_hit;

    assign twin_hit  = push && have_first_q && (gap_d == TWIN_GAP);
    assign TwinCount = twin_count_q;
`endif

    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_prime_q  <= '0;
            have_first_q  <= 1'b0;
            max_gap_q     <= '0;
            prime_count_q <= '0;
            overflow_q    <= 1'b0;
`ifdef TWIN_PRIME_EN
            twin_count_q  <= '0;
`endif
        end else begin
            if (push) begin
                last_prime_q  <= InNumber;
                have_first_q  <= 1'b1;
                prime_count_q <= prime_count_d;
                if (gap_d > max_gap_q) begin
                    max_gap_q <= gap_d;
                end
                if (prime_count_q == CNT_MAX) begin
                    overflow_q <= 1'b1;
                end
            end
`ifdef TWIN_PRIME_EN
            if (twin_hit) begin
                if (twin_count_q == CNT_MAX) begin
                    overflow_q <= 1'b1;
                end else begin
                    twin_count_q <= twin_count_q + CNT_ONE;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_prime_result_collector.sv
// Self-checking bench for prime_result_collector: queue-based reference model, one per-cycle
// compare process, directed scenarios plus randomized streams and output stalls.
module tb_prime_result_collector;

    localparam int NW    = 10;
    localparam int CW    = 8;
    localparam int DEPTH = 8;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int MAXW  = 200;

    typedef struct packed {
        logic [NW-1:0] num;
        logic [NW-1:0] gap;
    } m_ent_t;

    logic          SysClk   = 1'b0;
    logic          Reset_n  = 1'b0;
    logic          InValid  = 1'b0;
    logic [NW-1:0] InNumber = '0;
    logic          InPrime  = 1'b0;
    logic          InLast   = 1'b0;
    logic          rand_ready  = 1'b0;
    logic          ready_force = 1'b0;
    logic          rnd_bit     = 1'b0;
    logic          OutReady;
    logic          InReady;
    logic          OutValid;
    logic [NW-1:0] OutPrime;
    logic [NW-1:0] OutGap;
    logic [CW-1:0] PrimeCount;
    logic [NW-1:0] MaxGap;
    logic          Overflow;
    logic          Done;
`ifdef TWIN_PRIME_EN
    logic [CW-1:0] TwinCount;
`endif

    assign OutReady = rand_ready ? rnd_bit : ready_force;

    prime_result_collector dut (
        .SysClk     (SysClk),
        .Reset_n    (Reset_n),
        .InValid    (InValid),
        .InReady    (InReady),
        .InNumber   (InNumber),
        .InPrime    (InPrime),
        .InLast     (InLast),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutPrime   (OutPrime),
        .OutGap     (OutGap),
        .PrimeCount (PrimeCount),
        .MaxGap     (MaxGap),
        .Overflow   (Overflow),
`ifdef TWIN_PRIME_EN
        .TwinCount  (TwinCount),
`endif
        .Done       (Done)
    );

    always #5 SysClk = ~SysClk;

    always @(posedge SysClk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: the buffer is a plain queue; phase 0 = accepting, 1 = draining, 2 = done.
    m_ent_t        mq[$];
    m_ent_t        pops[$];
    logic [NW-1:0] m_last   = '0;
    logic [NW-1:0] m_maxgap = '0;
    bit            m_have   = 1'b0;
    bit            m_ovf    = 1'b0;
    int            m_count  = 0;
    int            m_twin   = 0;
    int            m_phase  = 0;
    int            acc_cnt  = 0;

    always @(posedge SysClk or negedge Reset_n) begin
        bit     acc;
        bit     pp;
        bit     was_empty;
        m_ent_t e;
        if (!Reset_n) begin
            mq.delete();
            pops.delete();
            m_last   = '0;
            m_maxgap = '0;
            m_have   = 1'b0;
            m_ovf    = 1'b0;
            m_count  = 0;
            m_twin   = 0;
            m_phase  = 0;
        end else begin
            was_empty = (mq.size() == 0);
            acc       = InValid && (m_phase == 0) && (mq.size() < DEPTH);
            pp        = !was_empty && OutReady;
            if (pp) begin
                e.num = OutPrime;
                e.gap = OutGap;
                pops.push_back(e);
                e = mq.pop_front();
            end
            if (acc) begin
                acc_cnt++;
                if (InPrime) begin
                    e.num = InNumber;
                    e.gap = m_have ? (InNumber - m_last) : '0;
                    if (m_have && e.gap == NW'(2)) begin
                        if (m_twin == CMAX) m_ovf = 1'b1;
                        else m_twin++;
                    end
                    if (e.gap > m_maxgap) m_maxgap = e.gap;
                    if (m_count == CMAX) m_ovf = 1'b1;
                    else m_count++;
                    m_last = InNumber;
                    m_have = 1'b1;
                    mq.push_back(e);
                end
                if (InLast) m_phase = 1;
            end else if (m_phase == 1 && was_empty) begin
                m_phase = 2;
            end
        end
    end

    always @(negedge SysClk) begin
        check("in_ready", InReady, (m_phase == 0) && (mq.size() < DEPTH));
        check("out_valid", OutValid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("out_prime", OutPrime, mq[0].num);
            check("out_gap", OutGap, mq[0].gap);
        end
        check("prime_count", PrimeCount, m_count);
        check("max_gap", MaxGap, m_maxgap);
        check("overflow", Overflow, m_ovf);
        check("done", Done, m_phase == 2);
`ifdef TWIN_PRIME_EN
        check("twin_count", TwinCount, m_twin);
`endif
    end

    task automatic step();
        @(posedge SysClk);
        #1;
    endtask

    task automatic do_reset();
        InValid = 1'b0;
        InLast  = 1'b0;
        Reset_n = 1'b0;
        repeat (2) @(posedge SysClk);
        #2;
        Reset_n = 1'b1;
        step();
    endtask

    task automatic send(input int n, input bit last);
        int start;
        InValid  = 1'b1;
        InNumber = n[NW-1:0];
        InPrime  = is_prime(n);
        InLast   = last;
        start    = acc_cnt;
        for (int t = 0; t < MAXW && acc_cnt == start; t++) step();
        check("send_accepted", acc_cnt != start, 1);
        InValid = 1'b0;
        InLast  = 1'b0;
    endtask

    task automatic idle_rand();
        int k;
        k = ($urandom_range(0, 3) == 0) ? 1 : 0;
        repeat (k) step();
    endtask

    task automatic wait_done(input int budget);
        for (int t = 0; t < budget && !Done; t++) step();
        check("wait_done", Done, 1);
    endtask

    // Stream in checker order: 1, 2, then odd numbers up to the limit; InLast on the final one.
    task automatic stream(input int limit, input bit gaps);
        send(1, 0);
        send(2, 0);
        for (int n = 3; n <= limit; n += 2) begin
            send(n, n + 2 > limit);
            if (gaps) idle_rand();
        end
    endtask

    int p2[9]  = '{2, 3, 5, 7, 11, 13, 17, 19, 23};
    int p4[14] = '{101, 103, 107, 109, 113, 127, 131, 137, 139, 149, 151, 157, 163, 167};

    initial begin
        int v;
        bit seen907;

        // Reset state
        do_reset();
        check("rst_in_ready", InReady, 1);
        check("rst_out_valid", OutValid, 0);
        check("rst_done", Done, 0);

        // 1: small stream, sink always ready
        ready_force = 1'b1;
        stream(9, 0);
        wait_done(50);
        check("t1_npops", pops.size(), 4);
        if (pops.size() == 4) begin
            check("t1_p0", pops[0].num, 2);  check("t1_g0", pops[0].gap, 0);
            check("t1_p1", pops[1].num, 3);  check("t1_g1", pops[1].gap, 1);
            check("t1_p2", pops[2].num, 5);  check("t1_g2", pops[2].gap, 2);
            check("t1_p3", pops[3].num, 7);  check("t1_g3", pops[3].gap, 2);
        end
        check("t1_count", PrimeCount, 4);
        check("t1_maxgap", MaxGap, 2);
        check("t1_done", Done, 1);

        // 2: backpressure until full, ninth prime held until one pop
        do_reset();
        ready_force = 1'b0;
        for (int i = 0; i < 8; i++) send(p2[i], 0);
        check("t2_full_ready", InReady, 0);
        InValid  = 1'b1;
        InNumber = NW'(p2[8]);
        InPrime  = 1'b1;
        repeat (4) step();
        check("t2_held_ready", InReady, 0);
        check("t2_held_head", OutPrime, 2);
        ready_force = 1'b1;
        step();
        ready_force = 1'b0;
        check("t2_after_pop_ready", InReady, 1);
        check("t2_after_pop_head", OutPrime, 3);
        step();
        check("t2_refull_ready", InReady, 0);
        InValid = 1'b0;
        ready_force = 1'b1;
        send(25, 1);
        wait_done(100);
        check("t2_npops", pops.size(), 9);
        for (int i = 0; i < 9 && i < pops.size(); i++) check("t2_order", pops[i].num, p2[i]);

        // 3: full 1..999 stream with random stalls on both sides
        do_reset();
        rand_ready = 1'b1;
        stream(999, 1);
        wait_done(3000);
        rand_ready = 1'b0;
        check("t3_count", PrimeCount, 168);
        check("t3_maxgap", MaxGap, 20);
        check("t3_overflow", Overflow, 0);
        check("t3_npops", pops.size(), 168);
        if (pops.size() > 0) check("t3_last", pops[pops.size()-1].num, 997);
        seen907 = 1'b0;
        foreach (pops[i]) if (pops[i].num == 907 && pops[i].gap == 20) seen907 = 1'b1;
        check("t3_gap907", seen907, 1);

        // 4: simultaneous push/pop at occupancy 4 across the pointer wrap
        do_reset();
        ready_force = 1'b0;
        for (int i = 0; i < 4; i++) send(p4[i], 0);
        ready_force = 1'b1;
        for (int i = 4; i < 14; i++) begin
            send(p4[i], 0);
            check("t4_head", OutPrime, p4[i-3]);
            check("t4_valid", OutValid, 1);
            check("t4_ready", InReady, 1);
        end
        send(169, 1);
        wait_done(100);
        check("t4_npops", pops.size(), 14);
        for (int i = 0; i < 14 && i < pops.size(); i++) check("t4_order", pops[i].num, p4[i]);

        // 5: reset mid-stream with three buffered entries
        do_reset();
        ready_force = 1'b0;
        send(11, 0);
        send(13, 0);
        send(17, 0);
        #2;
        Reset_n = 1'b0;
        #1;
        check("t5_valid", OutValid, 0);
        check("t5_count", PrimeCount, 0);
        check("t5_maxgap", MaxGap, 0);
        check("t5_done", Done, 0);
        #1;
        Reset_n = 1'b1;
        step();
        send(19, 0);
        check("t5_first_prime", OutPrime, 19);
        check("t5_first_gap", OutGap, 0);
        send(23, 0);
        ready_force = 1'b1;
        send(25, 1);
        wait_done(100);
        check("t5_npops", pops.size(), 2);
        if (pops.size() == 2) check("t5_gap2", pops[1].gap, 4);

`ifdef TWIN_PRIME_EN
        // 6: twin primes up to 100
        do_reset();
        ready_force = 1'b1;
        stream(100, 0);
        wait_done(100);
        check("t6_twin", TwinCount, 8);
`endif

        // 7: more primes than the counter holds, random order and stalls
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            do v = $urandom_range(2, 1000); while (!is_prime(v));
            send(v, i == 299);
            idle_rand();
        end
        wait_done(500);
        rand_ready = 1'b0;
        check("t7_count_sat", PrimeCount, CMAX);
        check("t7_overflow", Overflow, 1);
        check("t7_npops", pops.size(), 300);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
